// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for alu_muldiv_unit.
//   - funct codes of the supported operations
//   - FSM state encoding
//   - op-class decode (single-cycle / iterative / unsupported)
// Optional feature macro: DIVU_EN (when defined, DIVU is an iterative op;
// otherwise it decodes as unsupported).
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OPC_SINGLE = 2'd0,
    OPC_ITER   = 2'd1,
    OPC_UNSUP  = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] funct);
    op_class_e cls;
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT,
      F_SLL, F_SRL, F_MFHI, F_MFLO:     cls = OPC_SINGLE;
      F_MULTU:                          cls = OPC_ITER;
`ifdef DIVU_EN
      F_DIVU:                           cls = OPC_ITER;
`endif
      default:                          cls = OPC_UNSUP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative engine, one step per cycle, WIDTH steps.
//   Multiply: unsigned shift-add, {hi_o,lo_o} = a * b after WIDTH steps.
//   Divide (DIVU_EN only): restoring, lo_o = a / b, hi_o = a % b;
//   b == 0 naturally yields lo_o = all ones, hi_o = a.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           latch operands, clear accumulator and counter
//   div_i             at start: select divide (ignored without DIVU_EN)
//   step_i            perform one iteration this cycle
//   a_i, b_i          operands
//   last_o            the step taken this cycle is the final one
//   hi_o, lo_o        accumulator halves (product / remainder+quotient)
// Optional feature macro: DIVU_EN.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;

`ifdef DIVU_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
`else
  logic             unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_hi_q} + (opb_q[0] ? {1'b0, opa_q} : '0);
`ifdef DIVU_EN
    div_d     = div_q;
    // Partial remainder (high half) shifted left with the next dividend bit;
    // the extra MSB of div_diff is the borrow of the trial subtraction.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
`endif
    if (start_i) begin
      opa_d    = a_i;
      opb_d    = b_i;
      acc_hi_d = '0;
      acc_lo_d = '0;
      cnt_d    = '0;
`ifdef DIVU_EN
      div_d = div_i;
      if (div_i) acc_lo_d = a_i;
`endif
    end else if (step_i) begin
      cnt_d = cnt_q + (SHW+1)'(1);
`ifdef DIVU_EN
      if (div_q) begin
        acc_hi_d = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else
`endif
      begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        opb_d    = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
`ifdef DIVU_EN
      div_q    <= 1'b0;
`endif
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
`ifdef DIVU_EN
      div_q    <= div_d;
`endif
    end
  end

  assign last_o = step_i && (cnt_q == CNT_LAST);
  assign hi_o   = acc_hi_q;
  assign lo_o   = acc_lo_q;

endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: single-issue execute unit with valid/ready handshake.
//   Single-cycle logic/arith/shift ops and MFHI/MFLO produce a registered
//   result one edge after acceptance; MULTU (and DIVU with DIVU_EN) runs
//   WIDTH iterations in alu_seq_muldiv and writes {HI,LO}.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   request;  in_ready  unit idle, can accept
//   Signal     6-bit funct code
//   dataA/B    operands (shift amount = dataB[SHW-1:0])
//   out_valid  one-cycle result pulse; Output result; err unsupported funct
//   busy       iterative operation in progress
// Optional feature macro: DIVU_EN.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete from here
// MUL   | multiply iterations running
// DIV   | divide iterations running (DIVU_EN only)
// DONE  | write {HI,LO}, present LO with out_valid, return to IDLE
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] Output,
  output logic             err,
  output logic             busy
);

  state_e           state_q, state_d;
  op_class_e        cls;
  logic             accept;
  logic             eng_start, eng_step, eng_last;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] alu_res;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  assign cls    = op_class(Signal);
  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (eng_start) state_d = (Signal == F_DIVU) ? DIV : MUL;
      MUL, DIV: if (eng_last)  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    eng_step  = (state_q == MUL) || (state_q == DIV);
    eng_start = accept && (cls == OPC_ITER);
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_seq (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (eng_start),
    .div_i   (Signal == F_DIVU),
    .step_i  (eng_step),
    .a_i     (dataA),
    .b_i     (dataB),
    .last_o  (eng_last),
    .hi_o    (eng_hi),
    .lo_o    (eng_lo)
  );

  always_comb begin
    alu_res = '0;
    case (Signal)
      F_AND:  alu_res = dataA & dataB;
      F_OR:   alu_res = dataA | dataB;
      F_ADD:  alu_res = dataA + dataB;
      F_SUB:  alu_res = dataA - dataB;
      F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      F_SLL:  alu_res = dataA << dataB[SHW-1:0];
      F_SRL:  alu_res = dataA >> dataB[SHW-1:0];
      F_MFHI: alu_res = hi_q;
      F_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    if (state_q == DONE) begin
      hi_d        = eng_hi;
      lo_d        = eng_lo;
      out_d       = eng_lo;
      out_valid_d = 1'b1;
    end else if (accept && (cls != OPC_ITER)) begin
      out_valid_d = 1'b1;
      err_d       = (cls == OPC_UNSUP);
      out_d       = (cls == OPC_UNSUP) ? '0 : alu_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Output    = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit (WIDTH=32 main instance, plus a
// WIDTH=16 instance for the parametrised multiply). Build with DIVU_EN to
// exercise the divider.
module tb_alu_muldiv_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] res;
  logic        err;
  logic        busy;

  logic        in_valid16;
  logic        in_ready16;
  logic [5:0]  funct16;
  logic [15:0] a16, b16;
  logic        out_valid16;
  logic [15:0] res16;
  logic        err16;
  logic        busy16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Signal(funct), .dataA(a), .dataB(b), .out_valid(out_valid),
    .Output(res), .err(err), .busy(busy)
  );

  alu_muldiv_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .Signal(funct16), .dataA(a16), .dataB(b16), .out_valid(out_valid16),
    .Output(res16), .err(err16), .busy(busy16)
  );

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One single-cycle op from an idle unit; result sampled one edge later.
  task automatic do_single(input string nm, input logic [5:0] f, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] e, input logic ee);
    @(negedge clk);
    in_valid = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_out"}, res, e);
    chk({nm, "_err"}, err, ee);
  endtask

  // Iterative op: latency WIDTH+1 edges, in_ready low from acceptance until
  // the result cycle, then HI/LO read back through MFHI/MFLO.
  task automatic run_iter(input string nm, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
    int lat;
    int low;
    @(negedge clk);
    in_valid = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    lat = 1; low = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) low++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done"}, out_valid, 1);
    chk({nm, "_latency"}, 64'(lat - 1), 33);
    chk({nm, "_ready_low"}, 64'(low), 33);
    chk({nm, "_lo"}, res, exp_lo);
    chk({nm, "_err"}, err, 0);
    do_single({nm, "_mfhi"}, F_MFHI, 32'h0, 32'h0, exp_hi, 1'b0);
    do_single({nm, "_mflo"}, F_MFLO, 32'h0, 32'h0, exp_lo, 1'b0);
  endtask

  initial begin
    int t;
    int low16;

    vecs[0]  = '{"add",      F_ADD,  32'd7,         32'd5,         32'd12,        1'b0};
    vecs[1]  = '{"sub_neg",  F_SUB,  32'd3,         32'd5,         32'hFFFFFFFE,  1'b0};
    vecs[2]  = '{"slt_true", F_SLT,  32'hFFFFFFFF,  32'd1,         32'd1,         1'b0};
    vecs[3]  = '{"sll_31",   F_SLL,  32'd1,         32'd31,        32'h80000000,  1'b0};
    vecs[4]  = '{"slt_fals", F_SLT,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[5]  = '{"srl_4",    F_SRL,  32'h80000000,  32'd4,         32'h08000000,  1'b0};
    vecs[6]  = '{"sll_0",    F_SLL,  32'hA5A5A5A5,  32'd0,         32'hA5A5A5A5,  1'b0};
    vecs[7]  = '{"srl_32lo", F_SRL,  32'h12345678,  32'h00000020,  32'h12345678,  1'b0};
    vecs[8]  = '{"and",      F_AND,  32'hF0F0F0F0,  32'h0FF00FF0,  32'h00F000F0,  1'b0};
    vecs[9]  = '{"or",       F_OR,   32'hF0F0F0F0,  32'h0F0F0000,  32'hFFFFF0F0,  1'b0};
    vecs[10] = '{"add_wrap", F_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[11] = '{"unsup",    6'b111111, 32'd5,      32'd3,         32'd0,         1'b1};
    vecs[12] = '{"sub_wrap", F_SUB,  32'd0,         32'd1,         32'hFFFFFFFF,  1'b0};

    rst_n = 1'b0; in_valid = 1'b0; funct = '0; a = '0; b = '0;
    in_valid16 = 1'b0; funct16 = '0; a16 = '0; b16 = '0;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk({vecs[i-1].name, "_valid"}, out_valid, 1);
        chk({vecs[i-1].name, "_out"}, res, vecs[i-1].exp_out);
        chk({vecs[i-1].name, "_err"}, err, vecs[i-1].exp_err);
      end
      if (i < NV) begin
        in_valid = 1'b1; funct = vecs[i].f; a = vecs[i].x; b = vecs[i].y;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_pulse_end", out_valid, 0);

    run_iter("multu_ones", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    @(negedge clk);
    chk("mflo_pulse_end", out_valid, 0);

    // Reset in the middle of a multiply aborts it; HI/LO read back as zero.
    @(negedge clk);
    in_valid = 1'b1; funct = F_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("midmul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_single("post_rst_mfhi", F_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
    do_single("post_rst_mflo", F_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);

    // AND held during a multiply waits for IDLE, then completes one edge later.
    @(negedge clk);
    in_valid = 1'b1; funct = F_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    funct = F_AND; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
    t = 1;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("stall_mul_valid", out_valid, 1);
    chk("stall_mul_lo", res, 32'd12);
    chk("stall_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_and_valid", out_valid, 1);
    chk("stall_and_out", res, 32'hF000F000);
    chk("stall_and_err", err, 0);
    @(negedge clk);
    chk("stall_pulse_end", out_valid, 0);

`ifdef DIVU_EN
    run_iter("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    run_iter("divu_by0", F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
`else
    do_single("divu_unsup", F_DIVU, 32'd100, 32'd7, 32'd0, 1'b1);
`endif

    // WIDTH=16 instance: 0xFFFF * 2, latency 17.
    @(negedge clk);
    in_valid16 = 1'b1; funct16 = F_MULTU; a16 = 16'hFFFF; b16 = 16'h0002;
    @(negedge clk);
    in_valid16 = 1'b0;
    t = 1; low16 = 0;
    while (!out_valid16 && t < 200) begin
      if (!in_ready16) low16++;
      @(negedge clk);
      t++;
    end
    chk("w16_done", out_valid16, 1);
    chk("w16_latency", 64'(t - 1), 17);
    chk("w16_ready_low", 64'(low16), 17);
    chk("w16_lo", res16, 16'hFFFE);
    in_valid16 = 1'b1; funct16 = F_MFHI;
    @(negedge clk);
    in_valid16 = 1'b0;
    chk("w16_mfhi_valid", out_valid16, 1);
    chk("w16_mfhi", res16, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
